// File: rtl/dmac_pkg.sv
// Shared AXI field widths and the write-order queue entry for the DMA controller.
package dmac_pkg;

    localparam int unsigned IdWidth    = 4;
    localparam int unsigned AddrWidth  = 32;
    localparam int unsigned LenWidth   = 4;
    localparam int unsigned SizeWidth  = 3;
    localparam int unsigned BurstWidth = 2;
    localparam int unsigned DataWidth  = 32;
    localparam int unsigned StrbWidth  = 4;

    typedef struct packed {
        logic [IdWidth-1:0]  id;
        logic [LenWidth-1:0] len;
    } ord_entry_t;

endpackage

// File: rtl/dmac_wr_order_if.sv
// AW and W channel bundle around the write-order block: upstream AW, per-channel W, AXI slave side.
interface dmac_wr_order_if #(
    parameter int unsigned N_CH = 4
) ();
    import dmac_pkg::*;

    logic [IdWidth-1:0]      s_awid;
    logic [AddrWidth-1:0]    s_awaddr;
    logic [LenWidth-1:0]     s_awlen;
    logic [SizeWidth-1:0]    s_awsize;
    logic [BurstWidth-1:0]   s_awburst;
    logic                    s_awvalid;
    logic                    s_awready;

    logic [IdWidth-1:0]      m_awid;
    logic [AddrWidth-1:0]    m_awaddr;
    logic [LenWidth-1:0]     m_awlen;
    logic [SizeWidth-1:0]    m_awsize;
    logic [BurstWidth-1:0]   m_awburst;
    logic                    m_awvalid;
    logic                    m_awready;

    logic [N_CH-1:0]           ch_wvalid;
    logic [N_CH-1:0]           ch_wready;
    logic [DataWidth*N_CH-1:0] ch_wdata;
    logic [StrbWidth*N_CH-1:0] ch_wstrb;
    logic [N_CH-1:0]           ch_wlast;

    logic [IdWidth-1:0]      m_wid;
    logic [DataWidth-1:0]    m_wdata;
    logic [StrbWidth-1:0]    m_wstrb;
    logic                    m_wlast;
    logic                    m_wvalid;
    logic                    m_wready;

    // Seen from the ordering block.
    modport slave (
        input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_awready,
        output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        input  ch_wvalid, ch_wdata, ch_wstrb, ch_wlast,
        output ch_wready,
        output m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready
    );

    modport master (
        output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_awready,
        input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        output ch_wvalid, ch_wdata, ch_wstrb, ch_wlast,
        input  ch_wready,
        input  m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready
    );

endinterface

// File: rtl/dmac_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; flags depend on the count alone.
module dmac_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];

endmodule

// File: rtl/dmac_wr_order.sv
// Passes AW through and steers per-channel W beats to the AXI slave in AW issue order,
// flagging burst-length mismatches and out-of-range ids.
module dmac_wr_order
    import dmac_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmac_wr_order_if.slave bus,
    input  logic           err_clr_i,
    output logic           err_o
);

    ord_entry_t          push_entry, head;
    logic                full, empty, push, pop;
    logic                head_ok, bad_id, w_hs, bad_beat;
    logic [LenWidth-1:0] beat_cnt_q;
    logic                err_q;

    assign bus.m_awid    = bus.s_awid;
    assign bus.m_awaddr  = bus.s_awaddr;
    assign bus.m_awlen   = bus.s_awlen;
    assign bus.m_awsize  = bus.s_awsize;
    assign bus.m_awburst = bus.s_awburst;
    assign bus.m_awvalid = bus.s_awvalid & ~full & ~rst;
    assign bus.s_awready = bus.m_awready & ~full;

    assign push       = bus.s_awvalid & bus.m_awready & ~full & ~rst;
    assign push_entry = '{id: bus.s_awid, len: bus.s_awlen};

    dmac_sync_fifo #(
        .Width ($bits(ord_entry_t)),
        .Depth (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign head_ok = ~empty & (32'(head.id) < N_CH);
    assign bad_id  = ~empty & ~head_ok;

    always_comb begin
        bus.m_wvalid  = 1'b0;
        bus.m_wdata   = '0;
        bus.m_wstrb   = '0;
        bus.m_wlast   = 1'b0;
        bus.ch_wready = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (head_ok && head.id == IdWidth'(c)) begin
                bus.m_wvalid     = bus.ch_wvalid[c];
                bus.m_wdata      = bus.ch_wdata[c*DataWidth +: DataWidth];
                bus.m_wstrb      = bus.ch_wstrb[c*StrbWidth +: StrbWidth];
                bus.m_wlast      = bus.ch_wlast[c];
                bus.ch_wready[c] = bus.m_wready;
            end
        end
    end

    assign bus.m_wid = head.id;

    assign w_hs     = bus.m_wvalid & bus.m_wready;
    assign bad_beat = w_hs & (bus.m_wlast ? (beat_cnt_q != head.len) : (beat_cnt_q == head.len));
    // An out-of-range head is dropped without consuming a beat.
    assign pop      = bad_id | (w_hs & bus.m_wlast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (pop)       beat_cnt_q <= '0;
            else if (w_hs) beat_cnt_q <= beat_cnt_q + LenWidth'(1);

            if (bad_beat || bad_id) err_q <= 1'b1;
            else if (err_clr_i)     err_q <= 1'b0;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_dmac_wr_order.sv
// Directed bench for dmac_wr_order with a queue-based reference model checked every cycle.
module tb_dmac_wr_order;
    import dmac_pkg::*;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic err_clr_i;
    logic err_o;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    dmac_wr_order_if #(.N_CH(N_CH)) bus ();

    dmac_wr_order #(
        .N_CH  (N_CH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_clr_i (err_clr_i),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int ch, input logic v, input logic last, input logic [31:0] d);
        bus.ch_wvalid[ch]         = v;
        bus.ch_wlast[ch]          = last;
        bus.ch_wdata[ch*32 +: 32] = d;
        bus.ch_wstrb[ch*4 +: 4]   = 4'hf;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [3:0] len);
        bit done = 1'b0;
        bus.s_awvalid = 1'b1;
        bus.s_awid    = id;
        bus.s_awlen   = len;
        bus.s_awaddr  = 32'h1000_0000 + {24'h0, id, len};
        bus.s_awsize  = 3'd2;
        bus.s_awburst = 2'd1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (bus.s_awready && bus.m_awvalid) done = 1'b1;
            step();
        end
        bus.s_awvalid = 1'b0;
        if (!done) chk("aw_timeout", 64'd0, 64'd1);
    endtask

    // Reference model: queue of {id, len}, beat position in the head burst, sticky error.
    logic [7:0]      mq[$];
    int unsigned     m_beat;
    logic            m_err;
    logic            e_awv, e_awr, e_wv, m_full, bad, hs, wl, pop_m;
    logic [N_CH-1:0] e_rdy;
    int              h, hl;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_beat = 0;
            m_err  = 1'b0;
            chk("rst_aw", {bus.m_awvalid, bus.s_awready}, {1'b0, bus.m_awready});
            chk("rst_w", {bus.m_wvalid, bus.ch_wready}, '0);
            chk("rst_err", err_o, 0);
        end else begin
            m_full = (mq.size() == DEPTH);
            e_awv  = bus.s_awvalid & ~m_full;
            e_awr  = bus.m_awready & ~m_full;
            chk("aw_hs", {bus.m_awvalid, bus.s_awready}, {e_awv, e_awr});
            chk("aw_pass", {bus.m_awid, bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst},
                {bus.s_awid, bus.s_awaddr, bus.s_awlen, bus.s_awsize, bus.s_awburst});
            e_wv  = 1'b0;
            e_rdy = '0;
            bad   = 1'b0;
            hs    = 1'b0;
            wl    = 1'b0;
            if (mq.size() > 0) begin
                h  = int'(mq[0][7:4]);
                hl = int'(mq[0][3:0]);
                if (h < N_CH) begin
                    e_wv     = bus.ch_wvalid[h];
                    e_rdy[h] = bus.m_wready;
                    wl       = bus.ch_wlast[h];
                    hs       = e_wv & bus.m_wready;
                    chk("w_id", bus.m_wid, h);
                    if (e_wv)
                        chk("w_data", {bus.m_wdata, bus.m_wstrb, bus.m_wlast},
                            {bus.ch_wdata[h*32 +: 32], bus.ch_wstrb[h*4 +: 4], wl});
                end else begin
                    bad = 1'b1;
                end
            end
            chk("w_route", {bus.m_wvalid, bus.ch_wready}, {e_wv, e_rdy});
            chk("err", err_o, m_err);

            if (bad || (hs && (wl ? (m_beat != hl) : (m_beat == hl)))) m_err = 1'b1;
            else if (err_clr_i) m_err = 1'b0;
            pop_m = bad | (hs & wl);
            if (pop_m) m_beat = 0;
            else if (hs) m_beat++;
            if (pop_m) void'(mq.pop_front());
            if (bus.s_awvalid && e_awr) mq.push_back({bus.s_awid, bus.s_awlen});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        err_clr_i     = 1'b0;
        bus.s_awvalid = 1'b0;
        bus.s_awid    = '0;
        bus.s_awaddr  = '0;
        bus.s_awlen   = '0;
        bus.s_awsize  = '0;
        bus.s_awburst = '0;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        bus.ch_wvalid = '0;
        bus.ch_wlast  = '0;
        bus.ch_wdata  = '0;
        bus.ch_wstrb  = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Ordering: ch0 waits behind the earlier ch2 burst.
        send_aw(4'd2, 4'd3);
        send_aw(4'd0, 4'd0);
        set_w(0, 1'b1, 1'b1, 32'hA0A0_0000);
        #1 chk("ord_ch0_blocked", bus.ch_wready, 4'b0100);
        step();
        for (int b = 0; b < 4; b++) begin
            set_w(2, 1'b1, (b == 3), 32'hC200_0000 + b);
            #1 chk("ord_ch2_beat", {bus.m_wid, bus.ch_wready, bus.m_wdata},
                   {4'd2, 4'b0100, 32'hC200_0000 + b});
            step();
        end
        set_w(2, 1'b0, 1'b0, 32'h0);
        #1 chk("ord_ch0_beat", {bus.m_wid, bus.ch_wready, bus.m_wvalid, bus.m_wdata},
               {4'd0, 4'b0001, 1'b1, 32'hA0A0_0000});
        step();
        set_w(0, 1'b0, 1'b0, 32'h0);
        #1 chk("ord_no_err", {err_o, bus.m_wvalid}, 2'b00);
        step();

        // Full FIFO: fifth AW held off, and a same-cycle pop does not let it in.
        for (int i = 0; i < 4; i++) send_aw(4'(i), 4'd0);
        bus.s_awvalid = 1'b1;
        bus.s_awid    = 4'd1;
        bus.s_awlen   = 4'd0;
        #1 chk("full_aw_blocked", {bus.s_awready, bus.m_awvalid}, 2'b00);
        step();
        set_w(0, 1'b1, 1'b1, 32'h0000_00F0);
        #1 chk("full_pop_no_push", {bus.ch_wready[0], bus.s_awready}, 2'b10);
        step();
        set_w(0, 1'b0, 1'b0, 32'h0);
        #1 chk("full_accept_next", {bus.s_awready, bus.m_awvalid}, 2'b11);
        step();
        #1 chk("full_count4", {bus.s_awready, bus.m_awvalid}, 2'b00);
        bus.s_awvalid = 1'b0;
        step();
        for (int c = 0; c < 4; c++) set_w(c, 1'b1, 1'b1, 32'hD000_0000 + c);
        for (int i = 0; i < 4; i++) step();
        for (int c = 0; c < 4; c++) set_w(c, 1'b0, 1'b0, 32'h0);
        #1 chk("drain_empty", {bus.m_wvalid, bus.ch_wready}, 5'b0);
        step();

        // Early wlast on beat 2 of a 4-beat burst.
        send_aw(4'd1, 4'd3);
        set_w(1, 1'b1, 1'b0, 32'hB100_0000);
        step();
        set_w(1, 1'b1, 1'b0, 32'hB100_0001);
        step();
        set_w(1, 1'b1, 1'b1, 32'hB100_0002);
        #1 chk("short_err_pre", err_o, 0);
        step();
        #1 chk("short_err_set", {err_o, bus.ch_wready, bus.m_wvalid}, {1'b1, 4'b0000, 1'b0});
        set_w(1, 1'b0, 1'b0, 32'h0);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        #1 chk("short_err_clr", err_o, 0);
        step();

        // Out-of-range id is dropped in one cycle without consuming data.
        send_aw(4'd7, 4'd0);
        bus.ch_wvalid = '1;
        bus.ch_wlast  = '1;
        #1 chk("badid_no_ready", {bus.ch_wready, bus.m_wvalid, err_o}, 6'b0);
        step();
        #1 chk("badid_err", {err_o, bus.ch_wready}, {1'b1, 4'b0000});
        bus.ch_wvalid = '0;
        bus.ch_wlast  = '0;
        step();
        send_aw(4'd3, 4'd0);
        set_w(3, 1'b1, 1'b1, 32'h3333_0000);
        #1 chk("badid_next", {bus.ch_wready, bus.m_wid}, {4'b1000, 4'd3});
        step();
        set_w(3, 1'b0, 1'b0, 32'h0);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        #1 chk("badid_clr", err_o, 0);
        step();

        // Reset mid-burst with three entries queued.
        send_aw(4'd0, 4'd3);
        send_aw(4'd1, 4'd0);
        send_aw(4'd2, 4'd0);
        set_w(0, 1'b1, 1'b0, 32'hE000_0000);
        step();
        set_w(0, 1'b1, 1'b0, 32'hE000_0001);
        step();
        rst           = 1'b1;
        bus.s_awvalid = 1'b1;
        #1 chk("rst_now_w", {bus.m_wvalid, bus.ch_wready, err_o}, 6'b0);
        chk("rst_now_aw", {bus.m_awvalid, bus.s_awready}, 2'b01);
        bus.s_awvalid = 1'b0;
        step();
        step();
        rst = 1'b0;
        set_w(0, 1'b0, 1'b0, 32'h0);
        step();
        send_aw(4'd2, 4'd1);
        set_w(2, 1'b1, 1'b0, 32'hF200_0000);
        #1 chk("post_rst_beat0", {bus.m_wid, bus.ch_wready}, {4'd2, 4'b0100});
        step();
        set_w(2, 1'b1, 1'b1, 32'hF200_0001);
        step();
        set_w(2, 1'b0, 1'b0, 32'h0);
        bus.ch_wvalid = '1;
        #1 chk("post_rst_done", {err_o, bus.m_wvalid, bus.ch_wready}, 6'b0);
        bus.ch_wvalid = '0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
